// File: rtl/coarse_gain_pkg.sv
// -----------------------------------------------------------------------------
// coarse_gain_pkg
// Shared constants and helpers for the multi-channel coarse-gain limiter.
//   - default configuration values used as the top-level parameter defaults
//   - internal datapath width (input shifted by the largest gain + guard bit)
//   - saturation limits for a signed OUTPUT_WIDTH result
//   - gain clamp helper
// -----------------------------------------------------------------------------
package coarse_gain_pkg;

  localparam int CG_NUM_CHANNELS    = 2;
  localparam int CG_INPUT_WIDTH     = 16;
  localparam int CG_OUTPUT_WIDTH    = 14;
  localparam int CG_MAX_LOG2_GAIN   = 7;
  localparam int CG_WIDTH_LOG2_GAIN = 3;
  localparam int CG_SAT_CNT_WIDTH   = 16;

  // Width that holds any input shifted by the largest gain, plus one guard bit
  function automatic int cg_int_width(input int iw, input int max_g);
    return iw + max_g + 1;
  endfunction

  // Largest positive value representable in a signed ow-bit word
  function automatic longint cg_sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed ow-bit word
  function automatic longint cg_sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

  // Requests above the permitted maximum shift are pulled down to it
  function automatic int unsigned cg_clamp_gain(input int unsigned req,
                                                input int unsigned max_g);
    if (req > max_g) begin
      return max_g;
    end else begin
      return req;
    end
  endfunction

  localparam int     CG_INT_WIDTH = cg_int_width(CG_INPUT_WIDTH, CG_MAX_LOG2_GAIN);
  localparam longint CG_SAT_MAX   = cg_sat_max(CG_OUTPUT_WIDTH);
  localparam longint CG_SAT_MIN   = cg_sat_min(CG_OUTPUT_WIDTH);

endpackage

// File: rtl/coarse_gain_limiter_mc_lane.sv
// -----------------------------------------------------------------------------
// gain_limiter_lane
// One channel of the coarse-gain limiter: two register stages.
//   stage 1: sign-extended sample shifted left by the (clamped) gain, plus the
//            rounding increment flag
//   stage 2: add rounding half-LSB, drop the S = IW-OW fraction bits, saturate
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   s1_load_i         sample present at stage-1 input (valid_i)
//   s2_load_i         stage 1 holds a valid sample
//   x_i               signed input sample
//   gain_i            already-clamped log2 gain for this sample
//   round_en_i        1 = round half up, 0 = floor
//   data_o, sat_o     registered result and saturation flag (held when idle)
//   sat_nxt_o         saturation flag about to be registered into sat_o
// -----------------------------------------------------------------------------
module gain_limiter_lane
  import coarse_gain_pkg::*;
#(
  parameter int IW   = CG_INPUT_WIDTH,
  parameter int OW   = CG_OUTPUT_WIDTH,
  parameter int MAXG = CG_MAX_LOG2_GAIN,
  parameter int GW   = CG_WIDTH_LOG2_GAIN
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s1_load_i,
  input  logic          s2_load_i,
  input  logic [IW-1:0] x_i,
  input  logic [GW-1:0] gain_i,
  input  logic          round_en_i,
  output logic [OW-1:0] data_o,
  output logic          sat_o,
  output logic          sat_nxt_o
);

  localparam int W       = cg_int_width(IW, MAXG);
  localparam int S       = IW - OW;
  localparam int RND_POS = (S > 0) ? (S - 1) : 0;

  localparam logic signed [W-1:0] LIM_HI  = W'(cg_sat_max(OW));
  localparam logic signed [W-1:0] LIM_LO  = W'(cg_sat_min(OW));
  localparam logic signed [W-1:0] RND_ONE = {{(W-1){1'b0}}, 1'b1} << RND_POS;

  logic signed [W-1:0]  w_x_ext;
  logic signed [W-1:0]  w_shift;
  logic                 w_inc;
  logic signed [W-1:0]  w_sum;
  logic signed [W-1:0]  w_y;
  logic [OW-1:0]        w_data_nxt;
  logic                 w_sat_nxt;

  logic signed [W-1:0]  r_shift;
  logic                 r_inc;

  assign w_x_ext = {{(W-IW){x_i[IW-1]}}, x_i};
  assign w_shift = w_x_ext <<< gain_i;
  // With g >= S the shifted value has no fraction bits, so no increment
  assign w_inc   = round_en_i & (int'(gain_i) < S);

  // Stage 1: capture shifted value and rounding decision with the sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift <= {W{1'b0}};
      r_inc   <= 1'b0;
    end else if (s1_load_i) begin
      r_shift <= w_shift;
      r_inc   <= w_inc;
    end
  end

  // The guard bit makes the half-LSB add overflow-free, so a rounding carry
  // past the output range is caught by the saturation compare below.
  assign w_sum = r_shift + (r_inc ? RND_ONE : {W{1'b0}});
  assign w_y   = w_sum >>> S;

  // Saturate the requantised value into the signed output range
  always_comb begin
    w_data_nxt = w_y[OW-1:0];
    w_sat_nxt  = 1'b0;
    if (w_y > LIM_HI) begin
      w_data_nxt = LIM_HI[OW-1:0];
      w_sat_nxt  = 1'b1;
    end else if (w_y < LIM_LO) begin
      w_data_nxt = LIM_LO[OW-1:0];
      w_sat_nxt  = 1'b1;
    end else begin
      w_data_nxt = w_y[OW-1:0];
      w_sat_nxt  = 1'b0;
    end
  end

  // Stage 2: register result; hold the last value between valid samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o <= {OW{1'b0}};
      sat_o  <= 1'b0;
    end else if (s2_load_i) begin
      data_o <= w_data_nxt;
      sat_o  <= w_sat_nxt;
    end
  end

  assign sat_nxt_o = w_sat_nxt;

endmodule

// File: rtl/coarse_gain_limiter_mc.sv
// -----------------------------------------------------------------------------
// coarse_gain_limiter_mc
// Multi-channel pipelined coarse gain (x * 2**g) with requantisation to
// OUTPUT_WIDTH, truncate/round selection and saturation. Owns the active gain
// registers, the valid pipeline, per-channel saturation counters and sticky
// flags; the per-channel datapath lives in gain_limiter_lane.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   valid_i          input strobe shared by all channels
//   data_i           packed signed samples, channel k at [k*IW +: IW]
//   gain_i           packed requested log2 gains (shadow)
//   gain_load_i      copy gain_i into active gains at this clock edge
//   round_en_i       1 = round half up, 0 = floor
//   cnt_clr_i        clear counters and sticky flags (wins over increment)
//   valid_o          output strobe, two cycles after valid_i
//   data_o, sat_o    packed results and per-sample saturation flags
//   sat_sticky_o     per-channel sticky saturation flags
//   sat_cnt_o        per-channel saturating event counters
// -----------------------------------------------------------------------------
module coarse_gain_limiter_mc
  import coarse_gain_pkg::*;
#(
  parameter int NUM_CHANNELS    = CG_NUM_CHANNELS,
  parameter int INPUT_WIDTH     = CG_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH    = CG_OUTPUT_WIDTH,
  parameter int MAX_LOG2_GAIN   = CG_MAX_LOG2_GAIN,
  parameter int WIDTH_LOG2_GAIN = CG_WIDTH_LOG2_GAIN,
  parameter int SAT_CNT_WIDTH   = CG_SAT_CNT_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  valid_i,
  input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0]     data_i,
  input  logic [NUM_CHANNELS*WIDTH_LOG2_GAIN-1:0] gain_i,
  input  logic                                  gain_load_i,
  input  logic                                  round_en_i,
  input  logic                                  cnt_clr_i,
  output logic                                  valid_o,
  output logic [NUM_CHANNELS*OUTPUT_WIDTH-1:0]    data_o,
  output logic [NUM_CHANNELS-1:0]                 sat_o,
  output logic [NUM_CHANNELS-1:0]                 sat_sticky_o,
  output logic [NUM_CHANNELS*SAT_CNT_WIDTH-1:0]   sat_cnt_o
);

  localparam int NC = NUM_CHANNELS;
  localparam int GW = WIDTH_LOG2_GAIN;
  localparam int CW = SAT_CNT_WIDTH;

  logic [NC*GW-1:0]        r_gain;
  logic                    r_v1;
  logic                    r_valid;
  logic [NC-1:0]           r_sticky;
  logic [NC-1:0][CW-1:0]   r_cnt;
  logic [NC-1:0]           w_sat_nxt;
  logic [NC-1:0][GW-1:0]   w_gain_cl;

  // Active gain registers; a sample in the load cycle still sees the old gain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gain <= {(NC*GW){1'b0}};
    end else if (gain_load_i) begin
      r_gain <= gain_i;
    end
  end

  // Valid pipeline, advances every cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_v1    <= valid_i;
      r_valid <= r_v1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NC; k++) begin : g_lane
      assign w_gain_cl[k] = GW'(cg_clamp_gain(int'(r_gain[k*GW +: GW]),
                                              int'(MAX_LOG2_GAIN)));

      gain_limiter_lane #(
        .IW   (INPUT_WIDTH),
        .OW   (OUTPUT_WIDTH),
        .MAXG (MAX_LOG2_GAIN),
        .GW   (GW)
      ) u_lane (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s1_load_i  (valid_i),
        .s2_load_i  (r_v1),
        .x_i        (data_i[k*INPUT_WIDTH +: INPUT_WIDTH]),
        .gain_i     (w_gain_cl[k]),
        .round_en_i (round_en_i),
        .data_o     (data_o[k*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
        .sat_o      (sat_o[k]),
        .sat_nxt_o  (w_sat_nxt[k])
      );
    end
  endgenerate

  // Counters and sticky flags update on the same edge that registers sat_o,
  // so they line up with the output sample that saturated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '{default: {CW{1'b0}}};
      r_sticky <= {NC{1'b0}};
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (cnt_clr_i) begin
          r_cnt[i]    <= {CW{1'b0}};
          r_sticky[i] <= 1'b0;
        end else if (r_v1 && w_sat_nxt[i]) begin
          r_sticky[i] <= 1'b1;
          if (r_cnt[i] != {CW{1'b1}}) begin
            r_cnt[i] <= r_cnt[i] + {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign valid_o      = r_valid;
  assign sat_sticky_o = r_sticky;
  assign sat_cnt_o    = r_cnt;

endmodule

// File: tb/tb_coarse_gain_limiter_mc.sv
module tb_coarse_gain_limiter_mc;

  localparam int NC = 2;
  localparam int IW = 16;
  localparam int OW = 14;
  localparam int GW = 3;
  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic [NC*IW-1:0]   data_i;
  logic [NC*GW-1:0]   gain_i;
  logic               gain_load_i;
  logic               round_en_i;
  logic               cnt_clr_i;
  logic               valid_o;
  logic [NC*OW-1:0]   data_o;
  logic [NC-1:0]      sat_o;
  logic [NC-1:0]      sat_sticky_o;
  logic [NC*CW-1:0]   sat_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coarse_gain_limiter_mc #(
    .NUM_CHANNELS    (NC),
    .INPUT_WIDTH     (IW),
    .OUTPUT_WIDTH    (OW),
    .MAX_LOG2_GAIN   (7),
    .WIDTH_LOG2_GAIN (GW),
    .SAT_CNT_WIDTH   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .gain_i       (gain_i),
    .gain_load_i  (gain_load_i),
    .round_en_i   (round_en_i),
    .cnt_clr_i    (cnt_clr_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .sat_o        (sat_o),
    .sat_sticky_o (sat_sticky_o),
    .sat_cnt_o    (sat_cnt_o)
  );

  typedef struct {
    int   x0, x1, g0, g1;
    logic rnd;
    int   e0, e1;
    logic s0, s1;
    int   c0, c1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int sdata(input int k);
    logic [OW-1:0] t;
    t = data_o[k*OW +: OW];
    return int'($signed(t));
  endfunction

  function automatic int cnt(input int k);
    logic [CW-1:0] t;
    t = sat_cnt_o[k*CW +: CW];
    return int'(t);
  endfunction

  task automatic drive(input int x0, input int x1);
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    a = IW'(x0);
    b = IW'(x1);
    data_i = {b, a};
  endtask

  task automatic set_gain(input int g0, input int g1);
    logic [GW-1:0] a;
    logic [GW-1:0] b;
    a = GW'(g0);
    b = GW'(g1);
    gain_i = {b, a};
  endtask

  initial begin
    // x0, x1, g0, g1, round, exp0, exp1, sat0, sat1, cnt0, cnt1 (cumulative)
    vecs[0] = '{256,    0,    0, 0, 1'b0,   64,      0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{256,   -256,  3, 3, 1'b0,  512,   -512, 1'b0, 1'b0, 0, 0};
    vecs[2] = '{4096,  -4096, 3, 3, 1'b0, 8191,  -8192, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{-32768,-32768,0, 1, 1'b0, -8192, -8192, 1'b0, 1'b1, 1, 1};
    vecs[4] = '{6,     -6,    0, 0, 1'b0,    1,     -2, 1'b0, 1'b0, 1, 1};
    vecs[5] = '{6,     -6,    0, 0, 1'b1,    2,     -1, 1'b0, 1'b0, 1, 1};
    vecs[6] = '{32767,  5,    0, 1, 1'b1, 8191,      3, 1'b1, 1'b0, 2, 1};
    vecs[7] = '{64,    -1,    7, 7, 1'b1, 2048,    -32, 1'b0, 1'b0, 2, 1};
    vecs[8] = '{32764, -32768,0, 0, 1'b0, 8191,  -8192, 1'b0, 1'b0, 2, 1};

    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; gain_i = '0;
    gain_load_i = 1'b0; round_en_i = 1'b0; cnt_clr_i = 1'b0;

    #3;
    check("reset_valid", int'(valid_o), 0);
    check("reset_data", int'(data_o), 0);
    check("reset_cnt", int'(sat_cnt_o), 0);
    check("reset_sticky", int'(sat_sticky_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Table-driven single-sample vectors with exact 2-cycle latency check
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_gain(vecs[i].g0, vecs[i].g1);
      gain_load_i = 1'b1;
      @(negedge clk);
      gain_load_i = 1'b0;
      valid_i = 1'b1;
      round_en_i = vecs[i].rnd;
      drive(vecs[i].x0, vecs[i].x1);
      @(negedge clk);
      valid_i = 1'b0;
      check($sformatf("v%0d_valid_n1", i), int'(valid_o), 0);
      @(negedge clk);
      check($sformatf("v%0d_valid_n2", i), int'(valid_o), 1);
      check($sformatf("v%0d_data0", i), sdata(0), vecs[i].e0);
      check($sformatf("v%0d_data1", i), sdata(1), vecs[i].e1);
      check($sformatf("v%0d_sat0", i), int'(sat_o[0]), int'(vecs[i].s0));
      check($sformatf("v%0d_sat1", i), int'(sat_o[1]), int'(vecs[i].s1));
      check($sformatf("v%0d_cnt0", i), cnt(0), vecs[i].c0);
      check($sformatf("v%0d_cnt1", i), cnt(1), vecs[i].c1);
      check($sformatf("v%0d_sticky0", i), int'(sat_sticky_o[0]), int'(vecs[i].c0 != 0));
      check($sformatf("v%0d_sticky1", i), int'(sat_sticky_o[1]), int'(vecs[i].c1 != 0));
      @(negedge clk);
      check($sformatf("v%0d_hold_data0", i), sdata(0), vecs[i].e0);
      check($sformatf("v%0d_hold_valid", i), int'(valid_o), 0);
    end

    // Gain change in the middle of a continuous stream
    round_en_i = 1'b0;
    @(negedge clk);
    set_gain(0, 0);
    gain_load_i = 1'b1;
    @(negedge clk);
    gain_load_i = 1'b0;
    begin
      int s_exp[4];
      s_exp = '{64, 64, 512, 512};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          check($sformatf("stream%0d_valid", i), int'(valid_o), 1);
          check($sformatf("stream%0d_data0", i), sdata(0), s_exp[i-2]);
          check($sformatf("stream%0d_data1", i), sdata(1), s_exp[i-2]);
        end
        valid_i = (i < 4);
        drive(256, 256);
        set_gain(3, 3);
        gain_load_i = (i == 1);
      end
      valid_i = 1'b0;
      gain_load_i = 1'b0;
    end

    // Counter saturation at all-ones, then clear racing an increment
    @(negedge clk);
    cnt_clr_i = 1'b1;
    @(negedge clk);
    cnt_clr_i = 1'b0;
    check("clr_cnt0", cnt(0), 0);
    check("clr_sticky0", int'(sat_sticky_o[0]), 0);
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      drive(4096, 0);
      @(negedge clk);
    end
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cnt_hold_15", cnt(0), 15);
    check("cnt_hold_sticky", int'(sat_sticky_o[0]), 1);
    check("cnt_hold_ch1", cnt(1), 0);

    valid_i = 1'b1;
    drive(4096, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cnt_clr_i = 1'b1;
    @(negedge clk);
    cnt_clr_i = 1'b0;
    check("clr_race_sat", int'(sat_o[0]), 1);
    check("clr_race_cnt", cnt(0), 0);
    check("clr_race_sticky", int'(sat_sticky_o[0]), 0);
    @(negedge clk);
    check("after_clr_cnt", cnt(0), 1);
    check("after_clr_sticky", int'(sat_sticky_o[0]), 1);

    // Asynchronous reset in the middle of a stream
    drive(256, 256);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", int'(valid_o), 0);
    check("arst_data", int'(data_o), 0);
    check("arst_sat", int'(sat_o), 0);
    check("arst_sticky", int'(sat_sticky_o), 0);
    check("arst_cnt", int'(sat_cnt_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_valid_idle", int'(valid_o), 0);
    valid_i = 1'b1;
    drive(256, 256);
    @(negedge clk);
    valid_i = 1'b0;
    check("post_rst_valid_n1", int'(valid_o), 0);
    @(negedge clk);
    check("post_rst_valid_n2", int'(valid_o), 1);
    check("post_rst_data0", sdata(0), 64);
    check("post_rst_data1", sdata(1), 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
